// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a one-cycle registered instruction RAM: boot wait,
// valid/ready streaming, branch redirect, skid buffer with address replay. Option: FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    BOOT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_pc,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  halt,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count,
`endif
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target
);

  localparam int              CNT_W     = $clog2(BOOT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_boot_cnt;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic                    r_req_valid;
  logic [ADDR_WIDTH-1:0]   r_req_pc;
  logic                    r_skid_valid;
  logic [DATA_WIDTH-1:0]   r_skid_data;
  logic [ADDR_WIDTH-1:0]   r_skid_pc;

  logic w_inst_valid;
  logic w_accept;
  logic w_held;
  logic w_issue;
  logic w_skid_load;
  logic w_skid_drain;

  // Outputs are forced to their reset values while rst_n is low, even before the first edge.
  assign w_inst_valid = rst_n & (r_skid_valid | r_req_valid) & ~branch_taken;
  assign w_accept     = w_inst_valid & inst_ready;
  assign w_held       = r_req_valid & r_skid_valid & ~w_accept & ~branch_taken;
  assign w_issue      = (r_state == ST_RUN) & ~halt;
  assign w_skid_load  = r_req_valid & ((~r_skid_valid & ~w_accept) | (r_skid_valid & w_accept));
  assign w_skid_drain = r_skid_valid & w_accept;

  assign inst_valid = w_inst_valid;
  assign inst       = r_skid_valid ? r_skid_data : mem_q;
  assign inst_pc    = !rst_n ? RESET_PC : (r_skid_valid ? r_skid_pc : r_req_pc);
  // While held, re-read the in-flight address so the word is still on mem_q next cycle.
  assign mem_pc     = !rst_n ? RESET_PC : (w_held ? r_req_pc : r_pc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_BOOT;
      r_boot_cnt   <= '0;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (r_state == ST_BOOT) begin
        if (r_boot_cnt == BOOT_LAST) begin
          r_state <= ST_RUN;
        end else begin
          r_boot_cnt <= r_boot_cnt + CNT_W'(1);
        end
      end
      if (branch_taken) begin
        r_pc         <= branch_target;
        r_req_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else begin
        if (w_held) begin
          r_req_valid <= 1'b1;
        end else if (w_issue) begin
          r_req_valid <= 1'b1;
          r_req_pc    <= r_pc;
          r_pc        <= r_pc + ADDR_WIDTH'(1);
        end else begin
          r_req_valid <= 1'b0;
        end
        if (w_skid_load) begin
          r_skid_valid <= 1'b1;
        end else if (w_skid_drain) begin
          r_skid_valid <= 1'b0;
        end
      end
    end
  end

  // Skid payload carries no reset; r_skid_valid qualifies it.
  always_ff @(posedge clk) begin
    if (!branch_taken && w_skid_load) begin
      r_skid_data <= mem_q;
      r_skid_pc   <= r_req_pc;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_inst_valid && !inst_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded bench for fetch_ctrl with a behavioural one-cycle instruction RAM (ram[i] = i + 100).
module tb_fetch_ctrl;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_ready;
  logic          halt;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [DW-1:0] mem_q;
  logic [AW-1:0] mem_pc;
  logic [AW-1:0] inst_pc;
  logic [DW-1:0] inst;
  logic          inst_valid;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]   fetch_count;
  logic [31:0]   stall_count;
`endif

  int            vectors = 0;
  int            miscompares = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] sb_exp;

  always #5 clk = ~clk;

  fetch_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC('0), .BOOT_CYCLES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_pc(mem_pc),
    .mem_q(mem_q),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .halt(halt),
`ifdef FETCH_CTRL_PERF_EN
    .fetch_count(fetch_count),
    .stall_count(stall_count),
`endif
    .branch_taken(branch_taken),
    .branch_target(branch_target)
  );

  always @(posedge clk) mem_q <= 32'(mem_pc) + 32'd100;

  // Every accepted word must be the next expected address with its RAM contents.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_extra got pc=%0d inst=%0d want no delivery", inst_pc, inst);
      end else begin
        sb_exp = exp_q.pop_front();
        if (inst_pc !== sb_exp || inst !== 32'(sb_exp) + 32'd100) begin
          miscompares++;
          $display("FAIL sb_word got pc=%0d inst=%0d want pc=%0d inst=%0d",
                   inst_pc, inst, sb_exp, 32'(sb_exp) + 32'd100);
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; halt = 1'b0; branch_taken = 1'b0; branch_target = '0; inst_ready = 1'b1;
    exp_q.delete();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; halt = 1'b0; branch_taken = 1'b0; branch_target = '0; inst_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors += 3;
      if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", inst_valid); end
      if (mem_pc !== '0) begin miscompares++; $display("FAIL rst_mem_pc got %0d want 0", mem_pc); end
      if (inst_pc !== '0) begin miscompares++; $display("FAIL rst_inst_pc got %0d want 0", inst_pc); end
      cyc();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      vectors += 2;
      if (mem_pc !== AW'((c < 3) ? 0 : c - 2)) begin
        miscompares++; $display("FAIL boot_mem_pc c=%0d got %0d want %0d", c, mem_pc, (c < 3) ? 0 : c - 2);
      end
      if (inst_valid !== (c >= 3)) begin
        miscompares++; $display("FAIL boot_valid c=%0d got %b want %b", c, inst_valid, c >= 3);
      end
      cyc();
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL boot_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_stall;
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back(AW'(i));
    for (int c = 0; c <= 15; c++) begin
      inst_ready = !(c >= 8 && c <= 10);
      @(negedge clk);
      if (c >= 8 && c <= 10) begin
        vectors += 3;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid c=%0d got %b want 1", c, inst_valid); end
        if (inst_pc !== AW'(5)) begin miscompares++; $display("FAIL stall_pc c=%0d got %0d want 5", c, inst_pc); end
        if (mem_pc !== AW'(6)) begin miscompares++; $display("FAIL stall_replay c=%0d got %0d want 6", c, mem_pc); end
      end
      if (c >= 11 && c <= 13) begin
        vectors += 2;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL release_valid c=%0d got %b want 1", c, inst_valid); end
        if (inst_pc !== AW'(c - 6)) begin miscompares++; $display("FAIL release_pc c=%0d got %0d want %0d", c, inst_pc, c - 6); end
      end
`ifdef FETCH_CTRL_PERF_EN
      if (c == 15) begin
        vectors += 2;
        if (fetch_count !== 32'd9) begin miscompares++; $display("FAIL perf_fetch got %0d want 9", fetch_count); end
        if (stall_count !== 32'd3) begin miscompares++; $display("FAIL perf_stall got %0d want 3", stall_count); end
      end
`endif
      cyc();
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_branch;
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(AW'(i));
    for (int c = 0; c <= 16; c++) begin
      inst_ready    = !(c == 8 || c == 9);
      branch_taken  = (c == 9);
      branch_target = AW'(40);
      if (c == 9) for (int i = 40; i < 46; i++) exp_q.push_back(AW'(i));
      @(negedge clk);
      if (c == 9 || c == 10) begin
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL br_bubble c=%0d got %b want 0", c, inst_valid); end
      end
      if (c == 10) begin
        vectors++;
        if (mem_pc !== AW'(40)) begin miscompares++; $display("FAIL br_mem_pc got %0d want 40", mem_pc); end
      end
      if (c == 11) begin
        vectors += 2;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL br_valid got %b want 1", inst_valid); end
        if (inst_pc !== AW'(40)) begin miscompares++; $display("FAIL br_target got %0d want 40", inst_pc); end
      end
      cyc();
    end
    branch_taken = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL br_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 60; i < 67; i++) exp_q.push_back(AW'(i));
    for (int c = 0; c <= 9; c++) begin
      branch_taken  = (c == 0);
      branch_target = AW'(60);
      @(negedge clk);
      if (c == 2) begin
        vectors++;
        if (mem_pc !== AW'(60)) begin miscompares++; $display("FAIL wrap_first got %0d want 60", mem_pc); end
      end
      if (c == 6) begin
        vectors++;
        if (inst_pc !== AW'(63)) begin miscompares++; $display("FAIL wrap_top got %0d want 63", inst_pc); end
      end
      if (c == 7) begin
        vectors += 2;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got %b want 1", inst_valid); end
        if (inst_pc !== AW'(0)) begin miscompares++; $display("FAIL wrap_zero got %0d want 0", inst_pc); end
      end
      cyc();
    end
    branch_taken = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_drain got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_halt;
    do_reset();
    for (int i = 0; i < 7; i++) exp_q.push_back(AW'(i));
    for (int c = 0; c <= 13; c++) begin
      halt = (c >= 6 && c <= 9);
      @(negedge clk);
      if (c == 6) begin
        vectors += 2;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL halt_drain_valid got %b want 1", inst_valid); end
        if (inst_pc !== AW'(3)) begin miscompares++; $display("FAIL halt_drain_pc got %0d want 3", inst_pc); end
      end
      if (c >= 7 && c <= 10) begin
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL halt_idle c=%0d got %b want 0", c, inst_valid); end
      end
      if (c == 10) begin
        vectors++;
        if (mem_pc !== AW'(4)) begin miscompares++; $display("FAIL halt_resume_addr got %0d want 4", mem_pc); end
      end
      if (c == 11) begin
        vectors += 2;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL halt_resume_valid got %b want 1", inst_valid); end
        if (inst_pc !== AW'(4)) begin miscompares++; $display("FAIL halt_resume_pc got %0d want 4", inst_pc); end
      end
      cyc();
    end
    halt = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL halt_left got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(AW'(i));
    for (int c = 0; c <= 17; c++) begin
      inst_ready = !(c == 8 || c == 9);
      rst_n      = (c != 10);
      if (c == 10) for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
      @(negedge clk);
      if (c >= 11 && c <= 13) begin
        vectors += 2;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid c=%0d got %b want 0", c, inst_valid); end
        if (mem_pc !== AW'(0)) begin miscompares++; $display("FAIL mid_rst_mem_pc c=%0d got %0d want 0", c, mem_pc); end
      end
`ifdef FETCH_CTRL_PERF_EN
      if (c == 11) begin
        vectors += 2;
        if (fetch_count !== 32'd0) begin miscompares++; $display("FAIL mid_rst_fetch got %0d want 0", fetch_count); end
        if (stall_count !== 32'd0) begin miscompares++; $display("FAIL mid_rst_stall got %0d want 0", stall_count); end
      end
`endif
      if (c == 14) begin
        vectors += 2;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL mid_rst_restart_valid got %b want 1", inst_valid); end
        if (inst_pc !== AW'(0)) begin miscompares++; $display("FAIL mid_rst_restart_pc got %0d want 0", inst_pc); end
      end
      cyc();
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL mid_rst_left got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; branch_taken = 1'b0; branch_target = '0; inst_ready = 1'b1;
    cyc();
    test_reset();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid();
    rst_n = 1'b0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
